// File: rtl/vid_mem_pkg.sv
// Memory-map constants and region decode shared by the video peripheral bus logic.
package vid_mem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int PAL_DW = 24;

    // Local address widths of each video memory
    localparam int TB_AW  = 9;
    localparam int TG_AW  = 11;
    localparam int SG_AW  = 11;
    localparam int PAL_AW = 3;
    localparam int OAM_AW = 8;

    // Bus window spans; tile buffer and palette windows are larger than the memories (aliased)
    localparam logic [ADDR_W-1:0] TB_SPAN  = 12'h400;
    localparam logic [ADDR_W-1:0] TG_SPAN  = 12'h400;
    localparam logic [ADDR_W-1:0] SG_SPAN  = 12'h400;
    localparam logic [ADDR_W-1:0] PAL_SPAN = 12'h200;

    localparam logic [ADDR_W-1:0] TB_BASE  = 12'h000;
    localparam logic [ADDR_W-1:0] TG_BASE  = TB_BASE  + TB_SPAN;
    localparam logic [ADDR_W-1:0] SG_BASE  = TG_BASE  + TG_SPAN;
    localparam logic [ADDR_W-1:0] PAL_BASE = SG_BASE  + SG_SPAN;
    localparam logic [ADDR_W-1:0] OAM_BASE = PAL_BASE + PAL_SPAN;

    typedef enum logic [2:0] {
        NONE,
        TILE_BUF,
        TILE_GFX,
        SPR_GFX,
        PALETTE,
        OAM
    } region_t;

    // Every bus address lands in some region; NONE only exists as the idle read state
    function automatic region_t decode_region(input logic [ADDR_W-1:0] a);
        region_t r;
        if (a >= OAM_BASE)      r = OAM;
        else if (a >= PAL_BASE) r = PALETTE;
        else if (a >= SG_BASE)  r = SPR_GFX;
        else if (a >= TG_BASE)  r = TILE_GFX;
        else                    r = TILE_BUF;
        return r;
    endfunction

endpackage

// File: rtl/addr_decoder.sv
// Bus decoder for the tile/sprite video memories: combinational write strobes and
// slices, registered read-region select for the 1-cycle synchronous memory reads.
module addr_decoder
    import vid_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              chip_select,
    input  logic              write,
    input  logic              read,

    output logic              rw_tile_buffer,
    output logic              rw_tile_graphics,
    output logic              rw_sprite_graphics,
    output logic              rw_color_palettes,
    output logic              rw_OAM,

    output logic [DATA_W-1:0] write_data_tile_buffer,
    output logic [DATA_W-1:0] write_data_tile_graphics,
    output logic [DATA_W-1:0] write_data_sprite_graphics,
    output logic [DATA_W-1:0] write_data_OAM,
    output logic [PAL_DW-1:0] write_data_color_palettes,

    output logic [TB_AW-1:0]  addr_tile_buffer,
    output logic [TG_AW-1:0]  addr_tile_graphics,
    output logic [SG_AW-1:0]  addr_sprite_graphics,
    output logic [PAL_AW-1:0] addr_color_palettes,
    output logic [OAM_AW-1:0] addr_OAM,

    input  logic [DATA_W-1:0] readdata_tile_buffer,
    input  logic [DATA_W-1:0] readdata_tile_graphics,
    input  logic [DATA_W-1:0] readdata_sprite_graphics,
    input  logic [DATA_W-1:0] readdata_OAM,
    input  logic [PAL_DW-1:0] readdata_color_palettes,

    output logic [DATA_W-1:0] readdata
);

    region_t region;
    region_t rd_region;
    logic    wen;

    always_comb begin
        region = decode_region(addr);
        wen    = chip_select & write;

        rw_tile_buffer     = wen && (region == TILE_BUF);
        rw_tile_graphics   = wen && (region == TILE_GFX);
        rw_sprite_graphics = wen && (region == SPR_GFX);
        rw_color_palettes  = wen && (region == PALETTE);
        rw_OAM             = wen && (region == OAM);

        write_data_tile_buffer     = write_data;
        write_data_tile_graphics   = write_data;
        write_data_sprite_graphics = write_data;
        write_data_OAM             = write_data;
        write_data_color_palettes  = write_data[PAL_DW-1:0];

        addr_tile_buffer     = addr[TB_AW-1:0];
        addr_tile_graphics   = addr[TG_AW-1:0];
        addr_sprite_graphics = addr[SG_AW-1:0];
        addr_color_palettes  = addr[PAL_AW-1:0];
        addr_OAM             = addr[OAM_AW-1:0];

        // Memory data arrives one cycle after the read, so steer by the registered region
        readdata = '0;
        case (rd_region)
            TILE_BUF: readdata = readdata_tile_buffer;
            TILE_GFX: readdata = readdata_tile_graphics;
            SPR_GFX:  readdata = readdata_sprite_graphics;
            PALETTE:  readdata = {{(DATA_W-PAL_DW){1'b0}}, readdata_color_palettes};
            OAM:      readdata = readdata_OAM;
            default:  readdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_region <= NONE;
        else if (chip_select && read)
            rd_region <= region;
    end

endmodule

// File: tb/tb_addr_decoder.sv
// Directed checks of the video bus decoder: write strobes/slices, read steering, reset.
module tb_addr_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] addr;
    logic [31:0] write_data;
    logic        chip_select, write, read;
    logic        rw_tile_buffer, rw_tile_graphics, rw_sprite_graphics, rw_color_palettes, rw_OAM;
    logic [31:0] write_data_tile_buffer, write_data_tile_graphics, write_data_sprite_graphics, write_data_OAM;
    logic [23:0] write_data_color_palettes;
    logic [8:0]  addr_tile_buffer;
    logic [10:0] addr_tile_graphics, addr_sprite_graphics;
    logic [2:0]  addr_color_palettes;
    logic [7:0]  addr_OAM;
    logic [31:0] readdata_tile_buffer, readdata_tile_graphics, readdata_sprite_graphics, readdata_OAM;
    logic [23:0] readdata_color_palettes;
    logic [31:0] readdata;

    int n_assert = 0;
    int n_fail   = 0;

    addr_decoder dut (
        .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
        .chip_select(chip_select), .write(write), .read(read),
        .rw_tile_buffer(rw_tile_buffer), .rw_tile_graphics(rw_tile_graphics),
        .rw_sprite_graphics(rw_sprite_graphics), .rw_color_palettes(rw_color_palettes),
        .rw_OAM(rw_OAM),
        .write_data_tile_buffer(write_data_tile_buffer),
        .write_data_tile_graphics(write_data_tile_graphics),
        .write_data_sprite_graphics(write_data_sprite_graphics),
        .write_data_OAM(write_data_OAM),
        .write_data_color_palettes(write_data_color_palettes),
        .addr_tile_buffer(addr_tile_buffer), .addr_tile_graphics(addr_tile_graphics),
        .addr_sprite_graphics(addr_sprite_graphics), .addr_color_palettes(addr_color_palettes),
        .addr_OAM(addr_OAM),
        .readdata_tile_buffer(readdata_tile_buffer),
        .readdata_tile_graphics(readdata_tile_graphics),
        .readdata_sprite_graphics(readdata_sprite_graphics),
        .readdata_OAM(readdata_OAM),
        .readdata_color_palettes(readdata_color_palettes),
        .readdata(readdata)
    );

    always #5 clk = ~clk;

    // {tile_buffer, tile_graphics, sprite_graphics, color_palettes, OAM}
    wire [4:0] rw_vec = {rw_tile_buffer, rw_tile_graphics, rw_sprite_graphics,
                         rw_color_palettes, rw_OAM};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [11:0] a);
        @(negedge clk);
        chip_select = 1'b1; read = 1'b1; addr = a;
        @(posedge clk); #1;
        chip_select = 1'b0; read = 1'b0;
    endtask

    initial begin
        logic [4:0]  exp_rw;
        logic [11:0] ra;
        logic        rcs, rwr;

        reset = 1'b1;
        addr = '0; write_data = '0; chip_select = 1'b0; write = 1'b0; read = 1'b0;
        readdata_tile_buffer     = 32'h11111111;
        readdata_tile_graphics   = 32'h22222222;
        readdata_sprite_graphics = 32'h33333333;
        readdata_OAM             = 32'h12345678;
        readdata_color_palettes  = 24'hABCDEF;
        #2;
        check("reset_readdata", readdata, 32'h0);

        // write path is combinational and unaffected by reset
        chip_select = 1'b0; write = 1'b1; addr = 12'hABC; write_data = 32'hDEADBEEF; #1;
        check("cs0_no_strobe", {27'b0, rw_vec}, 32'h0);
        chip_select = 1'b1; write = 1'b0; addr = 12'h123; #1;
        check("wr0_no_strobe", {27'b0, rw_vec}, 32'h0);

        write = 1'b1; addr = 12'h0A5; write_data = 32'hAAAAAAAA; #1;
        check("tb_strobe", {27'b0, rw_vec}, 32'h10);
        check("tb_addr", {23'b0, addr_tile_buffer}, 32'h0A5);
        check("tb_wdata", write_data_tile_buffer, 32'hAAAAAAAA);
        addr = 12'h2A5; #1;
        check("tb_alias_strobe", {27'b0, rw_vec}, 32'h10);
        check("tb_alias_addr", {23'b0, addr_tile_buffer}, 32'h0A5);

        addr = 12'h5F0; write_data = 32'hBBBBBBBB; #1;
        check("tg_strobe", {27'b0, rw_vec}, 32'h08);
        check("tg_addr", {21'b0, addr_tile_graphics}, 32'h5F0);
        check("tg_wdata", write_data_tile_graphics, 32'hBBBBBBBB);
        addr = 12'h80F; write_data = 32'hCCCCCCCC; #1;
        check("sg_strobe", {27'b0, rw_vec}, 32'h04);
        check("sg_addr", {21'b0, addr_sprite_graphics}, 32'h00F);
        check("sg_wdata", write_data_sprite_graphics, 32'hCCCCCCCC);
        addr = 12'hC01; write_data = 32'hDDDDDDDD; #1;
        check("pal_strobe", {27'b0, rw_vec}, 32'h02);
        check("pal_addr", {29'b0, addr_color_palettes}, 32'h1);
        check("pal_wdata", {8'b0, write_data_color_palettes}, 32'h00DDDDDD);
        addr = 12'hDF9; #1;
        check("pal_top_strobe", {27'b0, rw_vec}, 32'h02);
        check("pal_top_addr", {29'b0, addr_color_palettes}, 32'h1);
        addr = 12'hEAA; write_data = 32'hEEEEEEEE; #1;
        check("oam_strobe", {27'b0, rw_vec}, 32'h01);
        check("oam_addr", {24'b0, addr_OAM}, 32'h0AA);
        check("oam_wdata", write_data_OAM, 32'hEEEEEEEE);
        addr = 12'hFAA; #1;
        check("oam_alias_strobe", {27'b0, rw_vec}, 32'h01);
        check("oam_alias_addr", {24'b0, addr_OAM}, 32'h0AA);
        chip_select = 1'b0; write = 1'b0;

        // read path
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("none_before_read", readdata, 32'h0);
        bus_read(12'hEAA);
        check("rd_oam", readdata, 32'h12345678);
        @(posedge clk); #1;
        check("rd_oam_hold", readdata, 32'h12345678);
        bus_read(12'hC00);
        check("rd_pal_zext", readdata, 32'h00ABCDEF);
        @(negedge clk); chip_select = 1'b0; read = 1'b1; addr = 12'hEAA;
        @(posedge clk); #1; read = 1'b0;
        check("rd_cs0_hold", readdata, 32'h00ABCDEF);
        bus_read(12'h2A5);
        check("rd_tb_alias", readdata, 32'h11111111);
        bus_read(12'h400);
        check("rd_tg", readdata, 32'h22222222);

        // simultaneous read and write both honoured
        @(negedge clk);
        chip_select = 1'b1; read = 1'b1; write = 1'b1; addr = 12'h80F; #1;
        check("rdwr_strobe", {27'b0, rw_vec}, 32'h04);
        @(posedge clk); #1;
        chip_select = 1'b0; read = 1'b0; write = 1'b0;
        check("rdwr_readdata", readdata, 32'h33333333);

        // asynchronous reset mid-stream
        @(negedge clk); #2; reset = 1'b1; #1;
        check("async_reset_rd", readdata, 32'h0);
        chip_select = 1'b1; write = 1'b1; addr = 12'h5F0; #1;
        check("reset_wr_path", {27'b0, rw_vec}, 32'h08);
        chip_select = 1'b0; write = 1'b0;
        @(negedge clk); reset = 1'b0;

        // random writes against an address-range reference
        for (int i = 0; i < 200; i++) begin
            ra  = 12'($urandom_range(0, 4095));
            rcs = 1'($urandom_range(0, 1));
            rwr = 1'($urandom_range(0, 1));
            addr = ra; chip_select = rcs; write = rwr; write_data = $urandom; #1;
            if (ra < 12'h400)      exp_rw = 5'b10000;
            else if (ra < 12'h800) exp_rw = 5'b01000;
            else if (ra < 12'hC00) exp_rw = 5'b00100;
            else if (ra < 12'hE00) exp_rw = 5'b00010;
            else                   exp_rw = 5'b00001;
            if (!(rcs && rwr)) exp_rw = 5'b00000;
            check("rand_strobe", {27'b0, rw_vec}, {27'b0, exp_rw});
            check("rand_slices", {addr_OAM, addr_color_palettes, addr_tile_buffer, 12'b0},
                  {ra[7:0], ra[2:0], ra[8:0], 12'b0});
            check("rand_wdata", {8'b0, write_data_color_palettes}, {8'b0, write_data[23:0]});
        end
        chip_select = 1'b0; write = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
